// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM state
// encoding, digit width, add-3 threshold and the bit-counter width.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    // A digit at or above this value is corrected before the next shift
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

    // Wide enough to hold the largest supported BIN_W (32)
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: adds 3 to a BCD digit that is
// 5 or more, so that the following left shift carries into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Pass the digit through unless it would overflow after doubling
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + ADD3_VALUE;
        end
    end

endmodule

// File: rtl/bin_to_bcd_param.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready
// handshakes on both sides. One operand bit is consumed per clock, so a
// conversion takes BIN_W cycles. Digits shifted past the top digit set a
// sticky overflow flag and the result is the magnitude modulo 10^DIGITS.
// Optional build macro: BIN_TO_BCD_SIGNED_EN (two's complement operand,
// magnitude converted and sign reported separately).
module bin_to_bcd_param
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            binary,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow,
    output logic                        sign
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              sign_q, sign_d;

    logic [BIN_W-1:0]  magnitude;
    logic              operand_sign;
    logic [BCD_W-1:0]  adj_digits;
    logic [SR_W-1:0]   adj_reg;

`ifdef BIN_TO_BCD_SIGNED_EN
    // Two's complement magnitude; the most negative value maps onto an
    // unsigned BIN_W-bit magnitude exactly, so no extra bit is needed
    always_comb begin
        operand_sign = binary[BIN_W-1];
        magnitude    = binary;
        if (operand_sign) begin
            magnitude = ~binary + BIN_W'(1);
        end
    end
`else
    // Unsigned operand: the magnitude is the operand itself
    always_comb begin
        operand_sign = 1'b0;
        magnitude    = binary;
    end
`endif

    // One correction cell per BCD digit of the shift register
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (shift_q[BIN_W + DIGIT_W*i +: DIGIT_W]),
            .digit_o (adj_digits[DIGIT_W*i +: DIGIT_W])
        );
    end

    assign adj_reg = {adj_digits, shift_q[BIN_W-1:0]};

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sign_d    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d = {{BCD_W{1'b0}}, magnitude};
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = 1'b0;
                    sign_d  = operand_sign;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = {adj_reg[SR_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                ovf_d   = ovf_q | adj_reg[SR_W-1];
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
        end
    end

    assign bcd      = shift_q[SR_W-1 -: BCD_W];
    assign overflow = ovf_q;
    assign sign     = sign_q;

endmodule

// File: tb/tb_bin_to_bcd_param.sv
// Scoreboard testbench for bin_to_bcd_param. Three instances are exercised:
// default (12 bits, 4 digits), 12 bits / 3 digits and 20 bits / 7 digits.
// Expected results come from a decimal-arithmetic reference model; a
// negedge monitor pops and compares whenever an instance presents a result.
module tb_bin_to_bcd_param;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic        sgn;
        int          lat;
    } exp_t;

    int wOf [3] = '{12, 12, 20};
    int dOf [3] = '{4, 3, 7};

    logic        clk;
    logic        reset_n;
    logic [2:0]  inValid;
    logic [2:0]  outReady;
    logic [31:0] binIn [3];

    logic [15:0] bcd0;
    logic [11:0] bcd1;
    logic [27:0] bcd2;
    logic [39:0] bcdW  [3];
    logic [2:0]  ovW, sgW, ovalW, irdyW;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    int checks = 0;
    int fails  = 0;
    int stall [3] = '{0, 0, 0};

    bit          tracking [3] = '{0, 0, 0};
    bit          seen     [3] = '{0, 0, 0};
    int          edges    [3] = '{0, 0, 0};
    logic [39:0] heldBcd  [3];
    logic        heldOv   [3];
    logic        heldSg   [3];
    exp_t        monE;

    bin_to_bcd_param #(.BIN_W(12), .DIGITS(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[0]), .in_ready(irdyW[0]),
        .binary(binIn[0][11:0]), .out_valid(ovalW[0]), .out_ready(outReady[0]),
        .bcd(bcd0), .overflow(ovW[0]), .sign(sgW[0])
    );

    bin_to_bcd_param #(.BIN_W(12), .DIGITS(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[1]), .in_ready(irdyW[1]),
        .binary(binIn[1][11:0]), .out_valid(ovalW[1]), .out_ready(outReady[1]),
        .bcd(bcd1), .overflow(ovW[1]), .sign(sgW[1])
    );

    bin_to_bcd_param #(.BIN_W(20), .DIGITS(7)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[2]), .in_ready(irdyW[2]),
        .binary(binIn[2][19:0]), .out_valid(ovalW[2]), .out_ready(outReady[2]),
        .bcd(bcd2), .overflow(ovW[2]), .sign(sgW[2])
    );

    assign bcdW[0] = {24'd0, bcd0};
    assign bcdW[1] = {28'd0, bcd1};
    assign bcdW[2] = {12'd0, bcd2};

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: decimal digits of the magnitude, modulo 10^digits
    function automatic exp_t model(longint raw, int w, int d);
        exp_t   e;
        longint mag;
        longint p;
        longint m;
        mag   = raw & ((64'sd1 <<< w) - 1);
        e.sgn = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        if (mag >= (64'sd1 <<< (w - 1))) begin
            e.sgn = 1'b1;
            mag   = (64'sd1 <<< w) - mag;
        end
`endif
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        e.ovf = (mag >= p);
        e.bcd = '0;
        m = mag % p;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.lat = w;
        return e;
    endfunction

    function automatic int qSize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t popExp(int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic pushExp(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Offer one operand to instance k, scribbling junk on the inputs while
    // the block is busy; the expected result is queued at the accept
    task automatic applyStimulus(int k, longint value);
        int waitCycles;
        bit accepted;
        waitCycles = 0;
        accepted   = 1'b0;
        while (!accepted) begin
            @(posedge clk);
            #1;
            if (irdyW[k]) begin
                binIn[k]   = 32'(value);
                inValid[k] = 1'b1;
                accepted   = 1'b1;
                pushExp(k, model(value, wOf[k], dOf[k]));
            end else begin
                inValid[k] = 1'($urandom_range(0, 1));
                binIn[k]   = $urandom;
                waitCycles++;
                if (waitCycles > 200) begin
                    checkOutput($sformatf("inst%0d in_ready timeout", k), 64'(irdyW[k]), 64'd1);
                    inValid[k] = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        inValid[k] = 1'b0;
        binIn[k]   = $urandom;
    endtask

    // Consumer side: random backpressure, or forced stall for a set number
    // of result-valid cycles
    initial begin
        outReady = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (stall[k] > 0) begin
                    outReady[k] = 1'b0;
                    if (ovalW[k]) stall[k]--;
                end else begin
                    outReady[k] = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    // Monitor: latency from accept, result against scoreboard, and
    // stability of the result while it waits for the consumer
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                tracking[k] = 1'b0;
                seen[k]     = 1'b0;
            end else begin
                if (tracking[k] && !seen[k]) edges[k]++;
                if (ovalW[k]) begin
                    checkOutput($sformatf("inst%0d in_ready while valid", k), 64'(irdyW[k]), 64'd0);
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        checkOutput($sformatf("inst%0d result expected", k), 64'(qSize(k) > 0), 64'd1);
                        if (qSize(k) > 0) begin
                            monE = popExp(k);
                            checkOutput($sformatf("inst%0d bcd", k), 64'(bcdW[k]), 64'(monE.bcd));
                            checkOutput($sformatf("inst%0d overflow", k), 64'(ovW[k]), 64'(monE.ovf));
                            checkOutput($sformatf("inst%0d sign", k), 64'(sgW[k]), 64'(monE.sgn));
                            checkOutput($sformatf("inst%0d latency", k),
                                        64'(tracking[k] ? edges[k] - 1 : 0), 64'(monE.lat));
                        end
                        heldBcd[k] = bcdW[k];
                        heldOv[k]  = ovW[k];
                        heldSg[k]  = sgW[k];
                    end else begin
                        checkOutput($sformatf("inst%0d bcd stable", k), 64'(bcdW[k]), 64'(heldBcd[k]));
                        checkOutput($sformatf("inst%0d overflow stable", k), 64'(ovW[k]), 64'(heldOv[k]));
                        checkOutput($sformatf("inst%0d sign stable", k), 64'(sgW[k]), 64'(heldSg[k]));
                    end
                    if (outReady[k]) begin
                        seen[k]     = 1'b0;
                        tracking[k] = 1'b0;
                    end
                end
                if (inValid[k] && irdyW[k]) begin
                    tracking[k] = 1'b1;
                    edges[k]    = 0;
                end
            end
        end
    end

    // Main sequence
    initial begin
        int guard;
        reset_n  = 1'b0;
        inValid  = 3'b000;
        for (int k = 0; k < 3; k++) binIn[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("inst%0d reset bcd", k), 64'(bcdW[k]), 64'd0);
            checkOutput($sformatf("inst%0d reset overflow", k), 64'(ovW[k]), 64'd0);
            checkOutput($sformatf("inst%0d reset sign", k), 64'(sgW[k]), 64'd0);
            checkOutput($sformatf("inst%0d reset out_valid", k), 64'(ovalW[k]), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("inst%0d in_ready after reset", k), 64'(irdyW[k]), 64'd1);

        // Default instance: full scale, zero with a held-off consumer,
        // signed extremes and digit-carry boundaries
        applyStimulus(0, 4095);
        applyStimulus(0, 0);
        stall[0] = 5;
        applyStimulus(0, 12'h800);
        applyStimulus(0, 12'h7FF);
        applyStimulus(0, 1);
        applyStimulus(0, 9);
        applyStimulus(0, 10);
        applyStimulus(0, 99);
        applyStimulus(0, 100);
        applyStimulus(0, 999);
        applyStimulus(0, 1000);
        for (int i = 0; i < 25; i++) applyStimulus(0, longint'($urandom_range(0, 4095)));

        // Reset in the middle of a conversion
        applyStimulus(0, 555);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid-conv reset bcd", 64'(bcdW[0]), 64'd0);
        checkOutput("mid-conv reset overflow", 64'(ovW[0]), 64'd0);
        checkOutput("mid-conv reset sign", 64'(sgW[0]), 64'd0);
        checkOutput("mid-conv reset out_valid", 64'(ovalW[0]), 64'd0);
        checkOutput("mid-conv reset in_ready", 64'(irdyW[0]), 64'd1);
        q0.delete();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after mid-conv reset", 64'(irdyW[0]), 64'd1);
        applyStimulus(0, 999);

        // Three digits: overflow and its clearing on the next operand
        applyStimulus(1, 1234);
        applyStimulus(1, 999);
        applyStimulus(1, 1000);
        applyStimulus(1, 0);
        applyStimulus(1, 4095);
        for (int i = 0; i < 6; i++) applyStimulus(1, longint'($urandom_range(0, 4095)));

        // Twenty-bit operand, seven digits
        applyStimulus(2, 1048575);
        applyStimulus(2, 999999);
        applyStimulus(2, 524288);
        for (int i = 0; i < 6; i++) applyStimulus(2, longint'($urandom & 32'hFFFFF));

        // Wait for every queued result to be delivered
        guard = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0 || ovalW != 3'b000) && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("pending results at end", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_param.md
BIN_TO_BCD_PARAM -- requirements
Module: bin_to_bcd_param

Interface
REQ-001 SHALL have parameter BIN_W, default 12: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port in_valid  input  1  binary operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port binary  input  BIN_W  operand, sampled only on the accept edge.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port bcd  output  4*DIGITS  result; digit 0 in bits [3:0].
REQ-011 SHALL have port overflow  output  1  magnitude is at least 10^DIGITS.
REQ-012 SHALL have port sign  output  1  result is negative (SIGNED_EN only, else 0).

Function
REQ-013 SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid in CONV or DONE is ignored with no side effect.
REQ-015 SHALL, on an accept (in_valid&&in_ready): latch the operand magnitude into the low BIN_W bits of a 4*DIGITS+BIN_W shift register, zero the digit field, load the bit counter with BIN_W, clear overflow and enter CONV.
REQ-016 SHALL, on each CONV cycle, add 3 to every digit >=5, then shift the register left by 1 in the same cycle, and decrement the counter.
REQ-017 SHALL set overflow (sticky within the conversion) when a 1 is shifted out of the top digit's MSB.
REQ-018 SHALL go CONV->DONE on the edge where the counter goes 1->0; out_valid SHALL first be high exactly BIN_W rising edges after the accept edge.
REQ-019 SHALL drive out_valid=1 only in DONE; bcd, overflow and sign SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 SHALL go DONE->IDLE on out_valid&&out_ready; there is no back-to-back accept in the same cycle.
REQ-021 SHALL, on overflow, output bcd equal to the magnitude modulo 10^DIGITS.
REQ-022 SHALL treat binary=0 as a normal conversion: full BIN_W-cycle latency and bcd=0.

Reset
REQ-023 SHALL, on reset_n=0 at any time (including mid-CONV or in DONE), immediately force IDLE with bcd=0, overflow=0, sign=0, out_valid=0, counter=0 and shift register=0.
REQ-024 SHALL drive in_ready=1 from the first rising edge after reset_n deasserts.

Configuration
REQ-025 SHALL, with macro BIN_TO_BCD_SIGNED_EN defined, treat binary as two's complement: magnitude=|binary|, sign=MSB of binary, and -2^(BIN_W-1) converted exactly.
REQ-026 SHALL, without BIN_TO_BCD_SIGNED_EN, treat binary as unsigned with sign tied 0; the port list SHALL be identical in both builds.

Structure
REQ-027 SHALL place the FSM state encoding, DIGIT_W=4 and the add-3 threshold constant in shared package bcd_pkg.
REQ-028 SHALL use one sub-module, bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5), instantiated DIGITS times by a generate loop.

Verification
REQ-029 SHALL cover: default params, binary=4095 -> bcd=16'h4095, overflow=0, out_valid 12 edges after accept.
REQ-030 SHALL cover: binary=0 -> bcd=16'h0000 after 12 cycles; then out_ready held 0 for 5 cycles -> bcd, out_valid and in_ready=0 all stable.
REQ-031 SHALL cover: DIGITS=3, binary=1234 -> bcd=12'h234, overflow=1.
REQ-032 SHALL cover: SIGNED_EN build, binary=12'hFFF -> sign=1, bcd=16'h0001; binary=12'h800 -> sign=1, bcd=16'h2048.
REQ-033 SHALL cover: reset_n pulsed low at CONV cycle 6 -> immediate IDLE with zero outputs; the next operand 999 -> bcd=16'h0999.
REQ-034 SHALL cover: BIN_W=20, DIGITS=7, binary=1048575 -> bcd=28'h1048575, latency 20 edges.
